fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 135 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a packetised AXI-stream; a popped word appears one cycle later.
// Backpressure: a 2-entry skid buffer absorbs tready stalls, so rd_en never depends on tready.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PACKET_LEN = 16
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst_n,
    input  logic                  i_enable,
    output logic                  o_busy,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_fifo_rd_en,
    output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
    output logic                  o_m_axis_tvalid,
    output logic                  o_m_axis_tlast,
    input  logic                  i_m_axis_tready,
    output logic                  o_pkt_done
);

    localparam int CW = $clog2(PACKET_LEN) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PACKET_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic                  vld0_q, vld0_d, vld1_q, vld1_d;
    logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  pop_allowed, rd_en, hs, new_last;

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Enable wins over the drain-complete exit so a re-request mid-drain resumes cleanly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_enable) state_d = RUN;
            RUN:     if (!i_enable) state_d = STOP;
            STOP: begin
                if (i_enable)                                state_d = RUN;
                else if ((pop_cnt_q == '0) && !vld0_q)       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_allowed = 1'b0;
        case (state_q)
            RUN:     pop_allowed = 1'b1;
            STOP:    pop_allowed = (pop_cnt_q != '0);
            default: pop_allowed = 1'b0;
        endcase
        rd_en  = pop_allowed && !i_fifo_empty && !vld1_q;
        o_busy = (state_q != IDLE) || vld0_q;
    end

    assign hs       = vld0_q && i_m_axis_tready;
    assign new_last = (pop_cnt_q == LAST_CNT);

    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (rd_en) pop_cnt_d = new_last ? '0 : pop_cnt_q + CW'(1);
    end

    // Entry 0 is always the head; entry 1 is only occupied while entry 0 is.
    always_comb begin
        dat0_d  = dat0_q;
        last0_d = last0_q;
        vld0_d  = vld0_q;
        dat1_d  = dat1_q;
        last1_d = last1_q;
        vld1_d  = vld1_q;
        if (hs) begin
            if (vld1_q) begin
                dat0_d  = dat1_q;
                last0_d = last1_q;
                vld1_d  = 1'b0;
                last1_d = 1'b0;
            end else if (rd_en) begin
                dat0_d  = i_fifo_rd_data;
                last0_d = new_last;
            end else begin
                vld0_d  = 1'b0;
                last0_d = 1'b0;
            end
        end else if (rd_en) begin
            if (vld0_q) begin
                dat1_d  = i_fifo_rd_data;
                last1_d = new_last;
                vld1_d  = 1'b1;
            end else begin
                dat0_d  = i_fifo_rd_data;
                last0_d = new_last;
                vld0_d  = 1'b1;
            end
        end
        pkt_done_d = hs && last0_q;
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            dat0_q     <= '0;
            last0_q    <= 1'b0;
            vld0_q     <= 1'b0;
            dat1_q     <= '0;
            last1_q    <= 1'b0;
            vld1_q     <= 1'b0;
            pop_cnt_q  <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            dat0_q     <= dat0_d;
            last0_q    <= last0_d;
            vld0_q     <= vld0_d;
            dat1_q     <= dat1_d;
            last1_q    <= last1_d;
            vld1_q     <= vld1_d;
            pop_cnt_q  <= pop_cnt_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign o_fifo_rd_en    = rd_en;
    assign o_m_axis_tdata  = dat0_q;
    assign o_m_axis_tvalid = vld0_q;
    assign o_m_axis_tlast  = last0_q;
    assign o_pkt_done      = pkt_done_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
    localparam int PL = 4;

    logic       clk, rst_n, enable, busy, fifo_empty, rd_en, tvalid, tlast, tready, pkt_done;
    logic [7:0] fifo_data, tdata;
    logic       rst_b_n, en_b, busy_b, empty_b, rd_b, tv_b, tl_b, tr_b, pd_b;
    logic [7:0] data_b, td_b;

    typedef struct packed { logic [7:0] d; logic l; } beat_t;
    logic [7:0] fifo_q[$];
    beat_t      exp_q[$];
    int         checks = 0, errors = 0, pops = 0;
    bit         rd_seen, tv_seen, hs_seen, pd_seen, bs_seen, b_done = 0;
    logic [7:0] td_seen;
    bit         prv_stall = 0, prv_hs_last = 0, prv_last;
    logic [7:0] prv_dat;

    fifo_stream_reader #(.DATA_WIDTH(8), .PACKET_LEN(PL)) dut (
        .i_clk(clk), .i_a_rst_n(rst_n), .i_enable(enable), .o_busy(busy),
        .i_fifo_empty(fifo_empty), .i_fifo_rd_data(fifo_data), .o_fifo_rd_en(rd_en),
        .o_m_axis_tdata(tdata), .o_m_axis_tvalid(tvalid), .o_m_axis_tlast(tlast),
        .i_m_axis_tready(tready), .o_pkt_done(pkt_done));

    fifo_stream_reader #(.DATA_WIDTH(8), .PACKET_LEN(1)) dut_b (
        .i_clk(clk), .i_a_rst_n(rst_b_n), .i_enable(en_b), .o_busy(busy_b),
        .i_fifo_empty(empty_b), .i_fifo_rd_data(data_b), .o_fifo_rd_en(rd_b),
        .o_m_axis_tdata(td_b), .o_m_axis_tvalid(tv_b), .o_m_axis_tlast(tl_b),
        .i_m_axis_tready(tr_b), .o_pkt_done(pd_b));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // One cycle: sample at negedge, then act as the FIFO at the edge just past.
    task automatic step();
        beat_t b;
        drive_fifo();
        @(negedge clk);
        rd_seen = rd_en; tv_seen = tvalid; hs_seen = tvalid && tready;
        td_seen = tdata; pd_seen = pkt_done; bs_seen = busy;
        @(posedge clk); #1;
        if (rd_seen && rst_n && fifo_q.size() != 0) begin
            b.d = fifo_q.pop_front();
            b.l = ((pops % PL) == PL - 1);
            exp_q.push_back(b);
            pops++;
        end
        drive_fifo();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prv_stall   = 0;
            prv_hs_last = 0;
        end else begin
            chk("pkt_done", pkt_done, prv_hs_last);
            chk("rd_en_while_empty", rd_en && fifo_empty, 0);
            if (prv_stall) begin
                chk("stall_tvalid", tvalid, 1);
                chk("stall_tdata", tdata, prv_dat);
                chk("stall_tlast", tlast, prv_last);
            end
            if (tvalid && tready) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e.d);
                    chk("tlast", tlast, e.l);
                end
            end
            prv_stall   = tvalid && !tready;
            prv_dat     = tdata;
            prv_last    = tlast;
            prv_hs_last = tvalid && tready && tlast;
        end
    end

    // Single-beat packets on the second instance
    initial begin
        logic [7:0] qb[$];
        logic [7:0] eb[$];
        int  pdb;
        bit  rdb;
        pdb = 0;
        qb = {8'h31, 8'h32, 8'h33};
        rst_b_n = 0; en_b = 0; tr_b = 1; empty_b = 0; data_b = qb[0];
        repeat (2) @(posedge clk);
        #1 rst_b_n = 1; en_b = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (tv_b && tr_b) begin
                chk("pl1_tlast", tl_b, 1);
                chk("pl1_beat_expected", eb.size() != 0, 1);
                if (eb.size() != 0) chk("pl1_tdata", td_b, eb.pop_front());
            end
            if (pd_b) pdb++;
            rdb = rd_b;
            @(posedge clk); #1;
            if (rdb && qb.size() != 0) eb.push_back(qb.pop_front());
            empty_b = (qb.size() == 0);
            data_b  = (qb.size() != 0) ? qb[0] : 8'h00;
        end
        chk("pl1_pkt_done_count", pdb, 3);
        chk("pl1_all_beats", eb.size() + qb.size(), 0);
        b_done = 1;
    end

    initial begin
        int first_rd, first_tv, rd_cnt, run, max_run, pd_cnt, base, n0, target;
        bit idle_seen;
        rst_n = 0; enable = 0; tready = 1; fifo_empty = 1; fifo_data = 0;
        @(posedge clk); #1;
        chk("rst_tvalid", tvalid, 0); chk("rst_tdata", tdata, 0); chk("rst_tlast", tlast, 0);
        chk("rst_rd_en", rd_en, 0); chk("rst_pkt_done", pkt_done, 0); chk("rst_busy", busy, 0);
        step(); step();
        rst_n = 1;

        // Back-to-back streaming of two packets
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + 8'(i));
        enable = 1;
        first_rd = -1; first_tv = -1; rd_cnt = 0; run = 0; max_run = 0; pd_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (rd_seen) begin rd_cnt++; run++; if (first_rd < 0) first_rd = c; end
            else run = 0;
            if (run > max_run) max_run = run;
            if (tv_seen && first_tv < 0) first_tv = c;
            if (pd_seen) pd_cnt++;
        end
        chk("burst_rd_cnt", rd_cnt, 8);
        chk("burst_rd_consecutive", max_run, 8);
        chk("burst_first_latency", first_tv - first_rd, 1);
        chk("burst_pkt_done_cnt", pd_cnt, 2);
        chk("burst_drained", exp_q.size(), 0);

        // Backpressure after beat 0x11
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + 8'(i));
        for (int k = 0; k < 20 && !(hs_seen && td_seen == 8'h11); k++) step();
        chk("bp_found_0x11", hs_seen && td_seen == 8'h11, 1);
        tready = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_hold_data", td_seen, 8'h12);
            chk("bp_hold_valid", tv_seen, 1);
        end
        chk("bp_rd_en_dropped", rd_seen, 0);
        tready = 1;
        repeat (12) step();
        chk("bp_drained", exp_q.size() + fifo_q.size(), 0);

        // Enable dropped mid-packet
        base = pops;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + 8'(i));
        for (int k = 0; k < 10 && pops - base < 2; k++) step();
        enable = 0;
        step();
        n0 = pops;
        target = ((n0 + PL - 1) / PL) * PL;
        repeat (6) step();
        rd_cnt = 0;
        for (int c = 0; c < 6; c++) begin step(); if (rd_seen) rd_cnt++; end
        chk("stop_pop_total", pops - base, 4);
        chk("stop_roundup", pops, target);
        chk("stop_fifo_left", fifo_q.size(), 4);
        chk("stop_rd_quiet", rd_cnt, 0);
        chk("stop_busy_low", bs_seen, 0);

        // FIFO runs dry mid-packet
        fifo_q.delete();
        fifo_q.push_back(8'h20); fifo_q.push_back(8'h21);
        enable = 1;
        repeat (8) step();
        chk("gap_tvalid_low", tv_seen, 0);
        chk("gap_rd_low", rd_seen, 0);
        fifo_q.push_back(8'h22); fifo_q.push_back(8'h23);
        repeat (6) step();
        chk("gap_drained", exp_q.size(), 0);

        // Reset with two words buffered
        tready = 0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h40 + 8'(i));
        repeat (5) step();
        chk("prerst_tvalid", tv_seen, 1);
        chk("prerst_rd_low", rd_seen, 0);
        rst_n = 0;
        #1;
        chk("arst_tvalid", tvalid, 0); chk("arst_tdata", tdata, 0); chk("arst_tlast", tlast, 0);
        chk("arst_rd_en", rd_en, 0); chk("arst_pkt_done", pkt_done, 0); chk("arst_busy", busy, 0);
        exp_q.delete();
        pops = 0;
        step(); step();
        rst_n = 1; tready = 1;
        for (int i = 4; i < 8; i++) fifo_q.push_back(8'h40 + 8'(i));
        repeat (14) step();
        chk("postrst_pops", pops, 6);
        chk("postrst_drained", exp_q.size(), 0);

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 99) < 55 && fifo_q.size() < 12) fifo_q.push_back(8'($urandom_range(0, 255)));
            tready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3) enable = !enable;
            step();
        end
        enable = 0; tready = 1; idle_seen = 0;
        for (int k = 0; k < 400 && !idle_seen; k++) begin
            while (fifo_q.size() < PL) fifo_q.push_back(8'($urandom_range(0, 255)));
            step();
            if (!bs_seen) idle_seen = 1;
        end
        chk("rand_idle_reached", idle_seen, 1);
        rd_cnt = 0;
        for (int c = 0; c < 5; c++) begin step(); if (rd_seen) rd_cnt++; end
        chk("rand_rd_quiet", rd_cnt, 0);
        chk("rand_whole_packets", pops % PL, 0);
        chk("rand_drained", exp_q.size(), 0);
        chk("pl1_done", b_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
